mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle RV32/RV64 control FSM: fetch, decode, memory access with timeout, writeback.
// Optional mul/div sequencing is enabled by defining MC_MULDIV_EN.
module mc_control_fsm #(
  parameter int unsigned BE_WIDTH    = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                mem_ready,
  input  logic                md_done,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src1,
  output logic                alu_src2,
  output logic                branch,
  output logic                jump,
  output logic                jal_or_jalr,
  output logic [2:0]          imm_sel,
  output logic [BE_WIDTH-1:0] be,
  output logic                md_start,
  output logic                trap,
  output logic [4:0]          state
);

  typedef enum logic [4:0] {
    StFetch   = 5'd0,  StDecode  = 5'd1,  StMemAddr = 5'd2,  StMemRd  = 5'd3,
    StLoadWb  = 5'd4,  StMemWr   = 5'd5,  StREx     = 5'd6,  StAluWb  = 5'd7,
    StBrEx    = 5'd8,  StJalEx   = 5'd9,  StJalrEx  = 5'd10, StJmpWb  = 5'd11,
    StIEx     = 5'd12, StUpperEx = 5'd13, StLuiWb   = 5'd14, StAuipcWb = 5'd15,
    StMdEx    = 5'd16, StTrap    = 5'd31
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [8:0] TimeoutCnt = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       is_store_q, is_store_d;
  logic [3:0] size_bytes;
  logic       size_ok;
  logic       waiting;
  logic       timed_out;

  assign size_bytes = 4'd1 << funct3[1:0];
  assign size_ok    = 32'(size_bytes) <= BE_WIDTH;
  assign waiting    = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr) && !mem_ready;
  assign timed_out  = ({1'b0, wait_q} + 9'd1) == TimeoutCnt;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= StFetch;
      wait_q     <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      is_store_q <= is_store_d;
    end
  end

`ifdef MC_MULDIV_EN
  logic md_first_q;
  always_ff @(posedge CLK) begin
    if (!RSTn) md_first_q <= 1'b0;
    else       md_first_q <= (state_d == StMdEx) && (state_q != StMdEx);
  end
  assign md_start = md_first_q && (state_q == StMdEx);
`else
  logic unused_md_done;
  assign unused_md_done = md_done;
  assign md_start       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      StFetch: begin
        if (mem_ready)      state_d = StDecode;
        else if (timed_out) state_d = StTrap;
      end
      StDecode: begin
        is_store_d = (opcode == OpStore);
        case (opcode)
          OpLoad, OpStore: state_d = StMemAddr;
          OpR: begin
            if (funct7 == 7'b0000001) begin
`ifdef MC_MULDIV_EN
              state_d = StMdEx;
`else
              state_d = StTrap;
`endif
            end else begin
              state_d = StREx;
            end
          end
          OpBranch:        state_d = StBrEx;
          OpJal:           state_d = StJalEx;
          OpJalr:          state_d = StJalrEx;
          OpImm:           state_d = StIEx;
          OpLui, OpAuipc:  state_d = StUpperEx;
          default:         state_d = StTrap;
        endcase
      end
      // Oversized accesses trap here so no strobe is ever issued for them.
      StMemAddr: state_d = !size_ok ? StTrap : (is_store_q ? StMemWr : StMemRd);
      StMemRd: begin
        if (mem_ready)      state_d = StLoadWb;
        else if (timed_out) state_d = StTrap;
      end
      StMemWr: begin
        if (mem_ready)      state_d = StFetch;
        else if (timed_out) state_d = StTrap;
      end
      StREx, StIEx:      state_d = StAluWb;
      StJalEx, StJalrEx: state_d = StJmpWb;
      StUpperEx:         state_d = (opcode == OpLui) ? StLuiWb : StAuipcWb;
      StLoadWb, StAluWb, StJmpWb, StLuiWb, StAuipcWb, StBrEx: state_d = StFetch;
`ifdef MC_MULDIV_EN
      StMdEx: if (md_done) state_d = StAluWb;
`else
      StMdEx: state_d = StTrap;
`endif
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase

    // Counter restarts on every state change so each wait state gets a fresh budget.
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + 8'd1;
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src1    = 1'b0;
    alu_src2    = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    jal_or_jalr = 1'b0;
    imm_sel     = 3'd0;
    be          = '0;
    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      StMemAddr: begin
        alu_src2 = 1'b1;
        imm_sel  = is_store_q ? 3'd5 : 3'd3;
      end
      StMemRd, StMemWr: begin
        mem_read  = (state_q == StMemRd);
        mem_write = (state_q == StMemWr);
        for (int i = 0; i < BE_WIDTH; i++) be[i] = (i < int'(size_bytes));
      end
      StLoadWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StAluWb, StJmpWb, StLuiWb, StAuipcWb: reg_write = 1'b1;
      StIEx: imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd6 : 3'd3;
      StBrEx: begin
        branch  = 1'b1;
        imm_sel = 3'd4;
      end
      StJalEx: begin
        jump     = 1'b1;
        alu_src1 = 1'b1;
        imm_sel  = 3'd2;
      end
      StJalrEx: begin
        jump        = 1'b1;
        jal_or_jalr = 1'b1;
        imm_sel     = 3'd3;
      end
      StUpperEx: begin
        alu_src1 = 1'b1;
        alu_src2 = 1'b1;
        imm_sel  = 3'd1;
      end
      default: ;
    endcase
  end

  assign trap  = (state_q == StTrap);
  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a vector table for the per-instruction flows plus
// hand sequences for timeout, reset-during-access, oversized access and mul/div.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       md_done;

  logic pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg;
  logic alu_src1, alu_src2, branch, jump, jal_or_jalr, md_start, trap;
  logic [2:0] imm_sel;
  logic [3:0] be;
  logic [4:0] state;

  logic pc_write8, ir_write8, mem_read8, mem_write8, reg_write8, mem_to_reg8;
  logic alu_src18, alu_src28, branch8, jump8, jal_or_jalr8, md_start8, trap8;
  logic [2:0] imm_sel8;
  logic [7:0] be8;
  logic [4:0] state8;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mc_control_fsm u_dut (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .md_done(md_done), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src1(alu_src1), .alu_src2(alu_src2), .branch(branch),
    .jump(jump), .jal_or_jalr(jal_or_jalr), .imm_sel(imm_sel), .be(be),
    .md_start(md_start), .trap(trap), .state(state)
  );

  mc_control_fsm #(.BE_WIDTH(8)) u_dut8 (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .md_done(md_done), .pc_write(pc_write8), .ir_write(ir_write8),
    .mem_read(mem_read8), .mem_write(mem_write8), .reg_write(reg_write8),
    .mem_to_reg(mem_to_reg8), .alu_src1(alu_src18), .alu_src2(alu_src28), .branch(branch8),
    .jump(jump8), .jal_or_jalr(jal_or_jalr8), .imm_sel(imm_sel8), .be(be8),
    .md_start(md_start8), .trap(trap8), .state(state8)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       rdy;
    logic       rstn;
    logic [4:0] st;
    logic [5:0] stb;  // {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg}
    logic [4:0] sel;  // {alu_src1, alu_src2, branch, jump, jal_or_jalr}
    logic [2:0] imm;
    logic [3:0] be4;
    logic [7:0] be8;
    logic       trap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic rdy, logic rstn,
                              logic [4:0] st, logic [5:0] stb, logic [4:0] sel,
                              logic [2:0] imm, logic [3:0] be4, logic [7:0] be8, logic tr);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = 7'd0; v.rdy = rdy; v.rstn = rstn; v.st = st; v.stb = stb;
    v.sel = sel; v.imm = imm; v.be4 = be4; v.be8 = be8; v.trap = tr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RSTn = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  initial begin
    // ADD
    vecs.push_back(mk(OP_R, 3'd0, 0, 1, 5'd0, 6'b001000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_R, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_R, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_R, 3'd0, 0, 1, 5'd6, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_R, 3'd0, 0, 1, 5'd7, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    // LW with a 3-cycle MEM_RD
    vecs.push_back(mk(OP_LOAD, 3'd2, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_LOAD, 3'd2, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_LOAD, 3'd2, 0, 1, 5'd2, 6'b000000, 5'b01000, 3'd3, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_LOAD, 3'd2, 0, 1, 5'd3, 6'b001000, 5'b00000, 3'd0, 4'hf, 8'h0f, 0));
    vecs.push_back(mk(OP_LOAD, 3'd2, 0, 1, 5'd3, 6'b001000, 5'b00000, 3'd0, 4'hf, 8'h0f, 0));
    vecs.push_back(mk(OP_LOAD, 3'd2, 1, 1, 5'd3, 6'b001000, 5'b00000, 3'd0, 4'hf, 8'h0f, 0));
    vecs.push_back(mk(OP_LOAD, 3'd2, 0, 1, 5'd4, 6'b000011, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    // SB
    vecs.push_back(mk(OP_STORE, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_STORE, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_STORE, 3'd0, 0, 1, 5'd2, 6'b000000, 5'b01000, 3'd5, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_STORE, 3'd0, 1, 1, 5'd5, 6'b000100, 5'b00000, 3'd0, 4'h1, 8'h01, 0));
    // BEQ
    vecs.push_back(mk(OP_BRANCH, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_BRANCH, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_BRANCH, 3'd0, 0, 1, 5'd8, 6'b000000, 5'b00100, 3'd4, 4'h0, 8'h00, 0));
    // JAL
    vecs.push_back(mk(OP_JAL, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_JAL, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_JAL, 3'd0, 0, 1, 5'd9, 6'b000000, 5'b10010, 3'd2, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_JAL, 3'd0, 0, 1, 5'd11, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    // JALR
    vecs.push_back(mk(OP_JALR, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_JALR, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_JALR, 3'd0, 0, 1, 5'd10, 6'b000000, 5'b00011, 3'd3, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_JALR, 3'd0, 0, 1, 5'd11, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    // SLLI then ADDI
    vecs.push_back(mk(OP_IMM, 3'd1, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd1, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd1, 0, 1, 5'd12, 6'b000000, 5'b00000, 3'd6, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd1, 0, 1, 5'd7, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd0, 0, 1, 5'd12, 6'b000000, 5'b00000, 3'd3, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_IMM, 3'd0, 0, 1, 5'd7, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    // LUI, AUIPC
    vecs.push_back(mk(OP_LUI, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_LUI, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_LUI, 3'd0, 0, 1, 5'd13, 6'b000000, 5'b11000, 3'd1, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_LUI, 3'd0, 0, 1, 5'd14, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_AUIPC, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_AUIPC, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_AUIPC, 3'd0, 0, 1, 5'd13, 6'b000000, 5'b11000, 3'd1, 4'h0, 8'h00, 0));
    vecs.push_back(mk(OP_AUIPC, 3'd0, 0, 1, 5'd15, 6'b000010, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    // Illegal opcode traps, trap is sticky, one reset edge clears it
    vecs.push_back(mk(7'd0, 3'd0, 1, 1, 5'd0, 6'b111000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(7'd0, 3'd0, 0, 1, 5'd1, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));
    vecs.push_back(mk(7'd0, 3'd0, 1, 1, 5'd31, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 1));
    vecs.push_back(mk(7'd0, 3'd0, 0, 1, 5'd31, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 1));
    vecs.push_back(mk(7'd0, 3'd0, 1, 0, 5'd31, 6'b000000, 5'b00000, 3'd0, 4'h0, 8'h00, 1));
    vecs.push_back(mk(7'd0, 3'd0, 0, 1, 5'd0, 6'b001000, 5'b00000, 3'd0, 4'h0, 8'h00, 0));

    reset_dut();
    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
      mem_ready = vecs[i].rdy; RSTn = vecs[i].rstn;
      #1;
      chk($sformatf("vec%0d", i),
          {state, pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
           alu_src1, alu_src2, branch, jump, jal_or_jalr, imm_sel, be, be8, trap},
          {vecs[i].st, vecs[i].stb, vecs[i].sel, vecs[i].imm, vecs[i].be4, vecs[i].be8,
           vecs[i].trap});
      tick();
    end
    RSTn = 1'b1;

    // FETCH timeout: 14 idle cycles still fetching, the 15th traps
    reset_dut();
    repeat (14) tick();
    chk("fetch_wait14", 32'(state), 32'd0);
    tick();
    chk("fetch_timeout", {27'd0, state, trap}, {27'd0, 5'd31, 1'b1});
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("trap_sticky", {26'd0, state, trap, pc_write}, {26'd0, 5'd31, 1'b1, 1'b0});
    RSTn = 1'b0;
    tick();
    RSTn = 1'b0 | 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("trap_reset", {26'd0, state, trap, mem_read}, {26'd0, 5'd0, 1'b0, 1'b1});

    // mem_ready on the final allowed cycle beats the timeout
    reset_dut();
    repeat (14) tick();
    mem_ready = 1'b1;
    #1;
    chk("ready_wins_pc", {27'd0, state, pc_write}, {27'd0, 5'd0, 1'b1});
    tick();
    chk("ready_wins_st", 32'(state), 32'd1);

    // LD: legal on the 8-lane build, traps from MEM_ADDR on the 4-lane build
    reset_dut();
    opcode = OP_LOAD; funct3 = 3'd3; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("ld_addr", 32'(state), 32'd2);
    tick();
    chk("ld_trap4", {26'd0, state, mem_read}, {26'd0, 5'd31, 1'b0});
    chk("ld_rd8", {18'd0, state8, mem_read8, be8}, {18'd0, 5'd3, 1'b1, 8'hff});

    // Reset while a store is waiting
    reset_dut();
    opcode = OP_STORE; funct3 = 3'd2; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    chk("sw_wait", {22'd0, state, mem_write, be}, {22'd0, 5'd5, 1'b1, 4'hf});
    tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    #1;
    chk("sw_reset", {20'd0, state, mem_write, mem_read, be, be8[0]},
        {20'd0, 5'd0, 1'b0, 1'b1, 4'h0, 1'b0});

    // MUL
    reset_dut();
    opcode = OP_R; funct3 = 3'd0; funct7 = 7'b0000001; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
`ifdef MC_MULDIV_EN
    chk("md_entry", {26'd0, state, md_start}, {26'd0, 5'd16, 1'b1});
    for (int k = 2; k <= 6; k++) begin
      tick();
      md_done = (k == 6);
      #1;
      chk($sformatf("md_wait%0d", k), {26'd0, state, md_start}, {26'd0, 5'd16, 1'b0});
    end
    tick();
    md_done = 1'b0;
    #1;
    chk("md_wb", {26'd0, state, reg_write}, {26'd0, 5'd7, 1'b1});
`else
    chk("md_trap", {25'd0, state, md_start, trap}, {25'd0, 5'd31, 1'b0, 1'b1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
